// File: rtl/dmem_pmu.sv
// Data-memory responder with memory-mapped power registers and the power-gating
// sequencer (ON -> ISO -> OFF -> PWRUP -> ON) driving the CPU domain controls.
//
// state | meaning
// ON    | core powered, accesses served
// ISO   | outputs clamped, power still on, dwell ISO_CYCLES
// OFF   | power removed, core held in reset, wait for wake/timer
// PWRUP | power restored, still clamped and in reset, dwell RAMP_CYCLES
module dmem_pmu #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
  parameter int unsigned ISO_CYCLES  = 2,
  parameter int unsigned RAMP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_wren,
  input  logic        dmem_rden,
  input  logic [31:0] dmem_wrdata,
  output logic [31:0] dmem_rddata,
  input  logic        wake_req,
  output logic        activate,
  output logic        isolate,
  output logic        cpu_rst
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] ISO_LOAD  = 16'(ISO_CYCLES - 1);
  localparam logic [15:0] RAMP_LOAD = 16'(RAMP_CYCLES - 1);

  typedef enum logic [1:0] {S_ON = 2'd0, S_ISO = 2'd1, S_OFF = 2'd2, S_PWRUP = 2'd3} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_dwell;
  logic [15:0] r_off_cnt;
  logic [15:0] r_sleep_cycles;
  logic [7:0]  r_wake_count;
  logic        r_activate, r_isolate, r_cpu_rst;
  logic        w_act_nxt, w_iso_nxt, w_rst_nxt;
  logic [31:0] r_mem [DEPTH];

  logic          w_in_ram, w_sel_ctrl, w_sel_sleep, w_sel_status, w_sel_wcnt;
  logic          w_acc_ok, w_sleep_req, w_timer_hit, w_off_exit;
  logic [AW-1:0] w_ram_idx;

  assign w_in_ram     = dmem_addr < 32'(DEPTH);
  assign w_ram_idx    = dmem_addr[AW-1:0];
  assign w_sel_ctrl   = dmem_addr == MMIO_BASE;
  assign w_sel_sleep  = dmem_addr == MMIO_BASE + 32'd1;
  assign w_sel_status = dmem_addr == MMIO_BASE + 32'd2;
  assign w_sel_wcnt   = dmem_addr == MMIO_BASE + 32'd3;
  assign w_acc_ok     = !r_isolate;
  assign w_sleep_req  = dmem_wren && w_acc_ok && w_sel_ctrl && dmem_wrdata[0];

  // r_off_cnt is 0 during the first OFF cycle, so +1 is the cycles spent in OFF
  assign w_timer_hit = (r_sleep_cycles != 16'd0) &&
                       ({1'b0, r_off_cnt} + 17'd1 == {1'b0, r_sleep_cycles});
  assign w_off_exit  = wake_req || w_timer_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_ON;
      r_dwell        <= '0;
      r_off_cnt      <= '0;
      r_sleep_cycles <= '0;
      r_wake_count   <= '0;
      r_activate     <= 1'b1;
      r_isolate      <= 1'b0;
      r_cpu_rst      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_activate <= w_act_nxt;
      r_isolate  <= w_iso_nxt;
      r_cpu_rst  <= w_rst_nxt;
      if (w_state_nxt != r_state)
        r_dwell <= (w_state_nxt == S_ISO) ? ISO_LOAD :
                   (w_state_nxt == S_PWRUP) ? RAMP_LOAD : 16'd0;
      else if (r_dwell != 16'd0)
        r_dwell <= r_dwell - 16'd1;
      r_off_cnt <= (r_state == S_OFF) ? r_off_cnt + 16'd1 : 16'd0;
      if (r_state == S_OFF && w_state_nxt == S_PWRUP)
        r_wake_count <= r_wake_count + 8'd1;
      if (dmem_wren && w_acc_ok && w_sel_sleep)
        r_sleep_cycles <= dmem_wrdata[15:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ON:    if (w_sleep_req) w_state_nxt = S_ISO;
      S_ISO:   if (r_dwell == 16'd0) w_state_nxt = S_OFF;
      S_OFF:   if (w_off_exit) w_state_nxt = S_PWRUP;
      S_PWRUP: if (r_dwell == 16'd0) w_state_nxt = S_ON;
      default: w_state_nxt = S_ON;
    endcase
  end

  // Outputs decoded from the next state and registered, so they are glitch-free
  always_comb begin
    w_act_nxt = 1'b1;
    w_iso_nxt = 1'b0;
    w_rst_nxt = 1'b0;
    case (w_state_nxt)
      S_ISO:   w_iso_nxt = 1'b1;
      S_OFF:   begin w_act_nxt = 1'b0; w_iso_nxt = 1'b1; w_rst_nxt = 1'b1; end
      S_PWRUP: begin w_iso_nxt = 1'b1; w_rst_nxt = 1'b1; end
      default: ;
    endcase
  end

  assign activate = r_activate;
  assign isolate  = r_isolate;
  assign cpu_rst  = r_cpu_rst;

  always_ff @(posedge clk) begin
    if (dmem_wren && w_acc_ok && w_in_ram)
      r_mem[w_ram_idx] <= dmem_wrdata;
  end

  always_comb begin
    dmem_rddata = '0;
    if (dmem_rden && w_acc_ok) begin
      if (w_in_ram)          dmem_rddata = r_mem[w_ram_idx];
      else if (w_sel_sleep)  dmem_rddata = {16'b0, r_sleep_cycles};
      else if (w_sel_status) dmem_rddata = {30'b0, r_state};
      else if (w_sel_wcnt)   dmem_rddata = {24'b0, r_wake_count};
    end
  end

endmodule
